// File: rtl/wb_stage.sv
// wb_stage: writeback stage selecting ALU/load/pc+4 results and pulsing the register-file write port
module wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] alu_out,
  input  logic [1:0]      wb_sel,
  input  logic            reg_wen,
  input  logic [4:0]      rd,
  input  logic [2:0]      funct3,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            load_err
);
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT_MEM = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  logic [1:0] state;
  logic [4:0] ld_rd;
  logic ld_wen;
  logic [2:0] ld_f3;
  logic [1:0] ld_off;
  logic accept, is_load, resp, ld_err;
  logic [XLEN-1:0] shifted, ld_data, alu_data;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  assign in_ready = state != WAIT_MEM;
  assign accept = in_valid & in_ready & ~flush;
  assign is_load = wb_sel == WB_MEM;
  assign resp = (state == WAIT_MEM) & mem_rvalid & ~flush;
  assign alu_data = wb_sel == WB_PC4 ? pc + 32'd4 : alu_out;
  assign shifted = mem_rdata >> {ld_off, 3'b000};
  assign byte_v = shifted[7:0];
  assign half_v = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  // funct3[2] selects zero extension (LBU/LHU)
  assign ld_data = ld_f3[1:0] == 2'b00 ? {{24{~ld_f3[2] & byte_v[7]}}, byte_v}
                 : ld_f3[1:0] == 2'b01 ? {{16{~ld_f3[2] & half_v[15]}}, half_v}
                 : mem_rdata;
  assign ld_err = ld_f3 == 3'b011 || ld_f3[2:1] == 2'b11
               || (ld_f3[1:0] == 2'b01 && ld_off[0])
               || (ld_f3 == 3'b010 && ld_off != 2'b00);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      load_err <= 1'b0;
      ld_rd <= '0;
      ld_wen <= 1'b0;
      ld_f3 <= '0;
      ld_off <= '0;
    end else begin
      rf_we <= 1'b0;
      load_err <= 1'b0;
      state <= flush ? IDLE : accept ? (is_load ? WAIT_MEM : WRITE)
             : resp ? WRITE : state == WAIT_MEM ? WAIT_MEM : IDLE;
      if (accept) begin
        ld_rd <= rd;
        ld_wen <= reg_wen;
        ld_f3 <= funct3;
        ld_off <= alu_out[1:0];
      end
      if (accept && !is_load && reg_wen && rd != 5'd0) begin
        rf_we <= 1'b1;
        rf_waddr <= rd;
        rf_wdata <= alu_data;
      end
      if (resp) begin
        load_err <= ld_err;
        if (!ld_err && ld_wen && ld_rd != 5'd0) begin
          rf_we <= 1'b1;
          rf_waddr <= ld_rd;
          rf_wdata <= ld_data;
        end
      end
    end
  end
endmodule
